svm_det_agg: RTL and testbench
==============================

# svm_det_agg

Detection post-processor between the SVM classifier and the board outputs, replacing the single-bit LED controller. Applies a runtime-programmable score threshold to each slide-window result, buffers accepted detections (window index plus score) in a parametrised FIFO for host readout over a valid/ready handshake, and produces per-frame detection counts. Also drives an LED with a programmable multi-frame hold.

## Interface
- SW_W, 11, slide-window index width
- FEA_W, 16, SVM score width (signed two's complement)
- SW_N, 1080, windows per frame; index SW_N-1 closes a frame
- DEPTH, 16, detection FIFO entries (power of two, ≥2)
- CNT_W, 8, per-frame detection counter width
- HOLD_W, 4, LED hold counter width
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_valid  in  1  SVM result strobe
- is_person  in  1  SVM decision bit
- sw_id  in  SW_W  window index of current result
- score  in  FEA_W  signed SVM score
- thr  in  FEA_W  signed threshold value
- thr_load  in  1  load thr into threshold register
- hold_fr  in  HOLD_W  LED hold length in frames, sampled at frame end
- det_valid  out  1  FIFO non-empty
- det_ready  in  1  consumer accepts head entry
- det_sw_id  out  SW_W  head entry window index
- det_score  out  FEA_W  head entry score
- frame_done  out  1  one-cycle pulse after the last window of a frame
- frame_cnt  out  CNT_W  detections in the last completed frame
- overflow  out  1  sticky: a detection was dropped in the current frame
- led  out  1  detection indicator

## Operation
- thr_r resets to 0; loads thr on thr_load. A load in the same cycle as a result takes effect from the next result.
- Detection = i_valid & is_person & (signed score > thr_r). Equal score is not a detection.
- Results with sw_id ≥ SW_N are ignored entirely: no detection, no frame end.
- Every detection is pushed as {sw_id, score}. When the FIFO is full and no pop occurs that cycle, the entry is dropped and overflow is set.
- Simultaneous push and pop while full: both succeed, no drop.
- Pop occurs on det_valid & det_ready. det_ready while empty has no effect.
- Running counter cur_cnt counts all detections, including dropped ones, saturating at 2^CNT_W-1.
- Frame end: i_valid & sw_id == SW_N-1. The following cycle: frame_done=1; frame_cnt = cur_cnt including any detection on the closing window; cur_cnt clears; overflow clears unless the closing window itself overflowed, in which case it stays set for one more frame.
- LED FSM:
  - IDLE (led=0): a frame end with count > 0 and hold_fr > 0 → ON, hold = hold_fr.
  - ON (led=1): a frame end with count > 0 reloads hold = hold_fr. A frame end with count 0 decrements hold; hold reaching 0 → IDLE.
  - hold_fr = 0 keeps the FSM in IDLE.

## Timing
- All outputs are registered.
- Reset values: det_valid=0, det_sw_id=0, det_score=0, frame_done=0, frame_cnt=0, overflow=0, led=0, FSM=IDLE, FIFO empty, cur_cnt=0.
- Detection at cycle t into an empty FIFO: det_valid=1 at t+1 with data valid.
- FIFO is show-ahead: after a pop, the next entry is on det_sw_id/det_score in the following cycle.
- Closing window at t: frame_done, frame_cnt and the LED transition are all visible at t+1.
- Reset asserted mid-frame clears all state immediately. The first frame after reset is whatever window sequence follows.
- Back-to-back i_valid every cycle is supported.

## Structure
- Package svm_det_pkg holds:
  - default SW_N, DEPTH, CNT_W and HOLD_W constants;
  - LED FSM state enum (IDLE, ON);
  - entry width constant SW_W+FEA_W.
- One sub-module, det_fifo:
  - parametrised synchronous FIFO with width and depth parameters;
  - read/write pointers with an extra wrap bit; full/empty flags;
  - show-ahead output register.
- Threshold, counters and FSM live in the top.

## Test plan
- thr=0x0100, scores 0x0100, 0x0101 and 0xFF00 (negative), each with is_person=1 → only 0x0101 is queued; det_score=0x0101 one cycle after the push.
- 20 detections with det_ready=0, DEPTH=16 → 16 entries held, overflow=1, frame_cnt=20 at frame end. Draining then yields the first 16 sw_ids in order.
- FIFO full, detection and pop in the same cycle → no drop, overflow stays 0, count stays 16.
- Frame of SW_N windows with 3 detections including one at sw_id=SW_N-1 → frame_done pulse one cycle later, frame_cnt=3.
- hold_fr=2: a frame with 1 detection, then two empty frames → led rises after frame 1, falls after the 2nd empty frame end.
- Reset asserted with 5 queued entries and led=1 → det_valid=0, led=0, frame_cnt=0 immediately; a sw_id ≥ SW_N result afterwards produces no output change.

Source files
------------

// File: rtl/svm_det_pkg.sv
// svm_det_pkg: shared constants and types for the
// SVM detection aggregator.
package svm_det_pkg;

    localparam int SW_W_D   = 11;
    localparam int FEA_W_D  = 16;
    localparam int SW_N_D   = 1080;
    localparam int DEPTH_D  = 16;
    localparam int CNT_W_D  = 8;
    localparam int HOLD_W_D = 4;
    localparam int ENT_W    = SW_W_D + FEA_W_D;

    typedef enum logic {
        IDLE = 1'b0,
        ON   = 1'b1
    } led_st_e;

endpackage

// File: rtl/svm_det_agg_if.sv
// svm_det_agg_if: detection readout handshake
// (show-ahead head entry, valid/ready).
interface svm_det_agg_if
    import svm_det_pkg::*;
#(
    parameter int SW_W  = SW_W_D,
    parameter int FEA_W = FEA_W_D
);

    logic             det_valid;
    logic             det_ready;
    logic [SW_W-1:0]  det_sw_id;
    logic [FEA_W-1:0] det_score;

    modport master (
        output det_valid,
        output det_sw_id,
        output det_score,
        input  det_ready
    );

    modport slave (
        input  det_valid,
        input  det_sw_id,
        input  det_score,
        output det_ready
    );

endinterface

// File: rtl/svm_det_agg_fifo.sv
// det_fifo: synchronous FIFO with wrap-bit pointers
// and a registered show-ahead head.
module det_fifo
    import svm_det_pkg::*;
#(
    parameter int W     = ENT_W,
    parameter int DEPTH = DEPTH_D
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         out_valid,
    output logic [W-1:0] dout,
    output logic         drop
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  wr_nxt;
    logic [AW:0]  rd_nxt;
    logic         empty;
    logic         full;
    logic         push_ok;
    logic         pop_ok;
    logic [W-1:0] head_nxt;

    always_comb begin
        empty   = wr_ptr == rd_ptr;
        full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        drop    = push && !push_ok;
        wr_nxt  = wr_ptr + {{AW{1'b0}}, push_ok};
        rd_nxt  = rd_ptr + {{AW{1'b0}}, pop_ok};
        // new head is the incoming word when it lands in the head slot
        if (push_ok && (rd_nxt == wr_ptr)) begin
            head_nxt = din;
        end else begin
            head_nxt = mem[rd_nxt[AW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            dout      <= '0;
        end else begin
            wr_ptr    <= wr_nxt;
            rd_ptr    <= rd_nxt;
            out_valid <= wr_nxt != rd_nxt;
            if (wr_nxt != rd_nxt) begin
                dout <= head_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/svm_det_agg.sv
// svm_det_agg: thresholds SVM results, queues detections,
// counts them per frame and drives a held LED.
module svm_det_agg
    import svm_det_pkg::*;
#(
    parameter int SW_W   = SW_W_D,
    parameter int FEA_W  = FEA_W_D,
    parameter int SW_N   = SW_N_D,
    parameter int DEPTH  = DEPTH_D,
    parameter int CNT_W  = CNT_W_D,
    parameter int HOLD_W = HOLD_W_D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic              is_person,
    input  logic [SW_W-1:0]   sw_id,
    input  logic [FEA_W-1:0]  score,
    input  logic [FEA_W-1:0]  thr,
    input  logic              thr_load,
    input  logic [HOLD_W-1:0] hold_fr,
    svm_det_agg_if.master     det,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              overflow,
    output logic              led
);

    localparam logic [SW_W-1:0] LAST = SW_W'(SW_N - 1);

    logic [FEA_W-1:0]      thr_r;
    logic [CNT_W-1:0]      cur_cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [HOLD_W-1:0]     hold;
    logic [HOLD_W-1:0]     hold_nxt;
    led_st_e               state;
    led_st_e               state_nxt;
    logic                  in_rng;
    logic                  det_hit;
    logic                  frame_end;
    logic                  pop;
    logic                  drop;
    logic                  hit_load;
    logic                  hit_zero;
    logic                  miss_on;
    logic [SW_W+FEA_W-1:0] head;

    always_comb begin
        in_rng    = i_valid && (32'(sw_id) < 32'(SW_N));
        det_hit   = in_rng && is_person &&
                    ($signed(score) > $signed(thr_r));
        frame_end = in_rng && (sw_id == LAST);
        pop       = det.det_valid && det.det_ready;
        cnt_nxt   = cur_cnt;
        if (det_hit && (cur_cnt != '1)) begin
            cnt_nxt = cur_cnt + CNT_W'(1);
        end
    end

    det_fifo #(
        .W     (SW_W + FEA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (det_hit),
        .din       ({sw_id, score}),
        .pop       (pop),
        .out_valid (det.det_valid),
        .dout      (head),
        .drop      (drop)
    );

    assign det.det_sw_id = head[FEA_W +: SW_W];
    assign det.det_score = head[FEA_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thr_r      <= '0;
            cur_cnt    <= '0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (thr_load) begin
                thr_r <= thr;
            end
            frame_done <= frame_end;
            // a drop on the closing window carries into the next frame
            if (frame_end) begin
                frame_cnt <= cnt_nxt;
                cur_cnt   <= '0;
                overflow  <= drop;
            end else begin
                cur_cnt  <= cnt_nxt;
                overflow <= overflow | drop;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            hold  <= '0;
            led   <= 1'b0;
        end else begin
            state <= state_nxt;
            hold  <= hold_nxt;
            led   <= state_nxt == ON;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        hit_load  = (cnt_nxt != '0) && (hold_fr != '0);
        hit_zero  = (cnt_nxt != '0) && (hold_fr == '0);
        miss_on   = (cnt_nxt == '0) && (state == ON);
        if (frame_end) begin
            unique case (1'b1)
                hit_load: begin
                    state_nxt = ON;
                    hold_nxt  = hold_fr;
                end
                hit_zero: begin
                    state_nxt = IDLE;
                    hold_nxt  = '0;
                end
                miss_on: begin
                    hold_nxt = hold - HOLD_W'(1);
                    if (hold == HOLD_W'(1)) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_svm_det_agg.sv
// tb_svm_det_agg: directed and randomized stimulus against
// a queue-based reference model of the aggregator.
module tb_svm_det_agg;
    import svm_det_pkg::*;

    localparam int SW_W   = SW_W_D;
    localparam int FEA_W  = FEA_W_D;
    localparam int SW_N   = SW_N_D;
    localparam int DEPTH  = DEPTH_D;
    localparam int CNT_W  = CNT_W_D;
    localparam int HOLD_W = HOLD_W_D;
    localparam logic [SW_W-1:0] LAST = SW_W'(SW_N - 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              i_valid;
    logic              is_person;
    logic [SW_W-1:0]   sw_id;
    logic [FEA_W-1:0]  score;
    logic [FEA_W-1:0]  thr;
    logic              thr_load;
    logic [HOLD_W-1:0] hold_fr;
    logic              frame_done;
    logic [CNT_W-1:0]  frame_cnt;
    logic              overflow;
    logic              led;

    always #5 clk = ~clk;

    svm_det_agg_if #(.SW_W(SW_W), .FEA_W(FEA_W)) dbus ();

    svm_det_agg #(
        .SW_W   (SW_W),
        .FEA_W  (FEA_W),
        .SW_N   (SW_N),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W),
        .HOLD_W (HOLD_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .is_person  (is_person),
        .sw_id      (sw_id),
        .score      (score),
        .thr        (thr),
        .thr_load   (thr_load),
        .hold_fr    (hold_fr),
        .det        (dbus),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .overflow   (overflow),
        .led        (led)
    );

    typedef struct {
        logic [SW_W-1:0]  id;
        logic [FEA_W-1:0] sc;
    } ent_t;

    ent_t                    q[$];
    int                      m_cur;
    int                      m_fcnt;
    int                      m_hold;
    bit                      m_fdone;
    bit                      m_ovf;
    bit                      m_led;
    logic signed [FEA_W-1:0] m_thr;
    int                      n_chk = 0;
    int                      n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cur   = 0;
        m_fcnt  = 0;
        m_hold  = 0;
        m_fdone = 0;
        m_ovf   = 0;
        m_led   = 0;
        m_thr   = '0;
    endtask

    task automatic model_step();
        bit   hit;
        bit   fe;
        bit   drop;
        int   cnt;
        ent_t e;
        hit  = i_valid && (int'(sw_id) < SW_N) && is_person &&
               ($signed(score) > m_thr);
        fe   = i_valid && (sw_id == LAST);
        drop = 0;
        if ((q.size() > 0) && dbus.det_ready) void'(q.pop_front());
        if (hit) begin
            if (q.size() < DEPTH) begin
                e.id = sw_id;
                e.sc = score;
                q.push_back(e);
            end else begin
                drop = 1;
            end
        end
        cnt = hit ? ((m_cur < 255) ? m_cur + 1 : 255) : m_cur;
        m_fdone = fe;
        if (fe) begin
            m_fcnt = cnt;
            m_cur  = 0;
            m_ovf  = drop;
            if (cnt > 0) begin
                m_led  = (hold_fr != 0);
                m_hold = int'(hold_fr);
            end else if (m_led) begin
                m_hold--;
                if (m_hold == 0) m_led = 0;
            end
        end else begin
            m_cur = cnt;
            m_ovf = m_ovf | drop;
        end
        if (thr_load) m_thr = thr;
    endtask

    task automatic check_all();
        chk("det_valid", 32'(dbus.det_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("det_sw_id", 32'(dbus.det_sw_id), 32'(q[0].id));
            chk("det_score", 32'(dbus.det_score), 32'(q[0].sc));
        end
        chk("frame_done", 32'(frame_done), 32'(m_fdone));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("led", 32'(led), 32'(m_led));
    endtask

    task automatic step(input logic v, input logic p,
                        input logic [SW_W-1:0] id,
                        input logic [FEA_W-1:0] sc,
                        input logic rdy);
        i_valid        = v;
        is_person      = p;
        sw_id          = id;
        score          = sc;
        dbus.det_ready = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, '0, '0, rdy);
    endtask

    task automatic close(input logic rdy);
        step(1'b1, 1'b0, LAST, '0, rdy);
    endtask

    logic            p;
    int              r;
    int              rdy_pct;
    logic [SW_W-1:0] rid;

    initial begin
        rst            = 1'b1;
        i_valid        = 1'b0;
        is_person      = 1'b0;
        sw_id          = '0;
        score          = '0;
        thr            = '0;
        thr_load       = 1'b0;
        hold_fr        = '0;
        dbus.det_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(dbus.det_valid), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_cnt", 32'(frame_cnt), 0);
        check_all();
        rst = 1'b0;

        // threshold: equal and negative scores rejected
        thr      = 16'h0100;
        thr_load = 1'b1;
        idle(1'b0);
        thr_load = 1'b0;
        step(1'b1, 1'b1, 11'd1, 16'h0100, 1'b0);
        chk("thr_eq", 32'(dbus.det_valid), 0);
        step(1'b1, 1'b1, 11'd2, 16'h0101, 1'b0);
        chk("thr_gt_valid", 32'(dbus.det_valid), 1);
        chk("thr_gt_score", 32'(dbus.det_score), 32'h0101);
        step(1'b1, 1'b1, 11'd3, 16'hFF00, 1'b0);
        idle(1'b1);
        chk("thr_neg_empty", 32'(dbus.det_valid), 0);
        close(1'b1);

        // overflow: 20 pushes into 16 slots
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b1, 11'(10 + i), 16'h0200, 1'b0);
        chk("ovf_set", 32'(overflow), 1);
        close(1'b0);
        chk("ovf_done", 32'(frame_done), 1);
        chk("ovf_fcnt", 32'(frame_cnt), 20);
        chk("ovf_clr", 32'(overflow), 0);
        for (int i = 0; i < 16; i++) begin
            chk("drain_id", 32'(dbus.det_sw_id), 32'(10 + i));
            idle(1'b1);
        end
        chk("drain_empty", 32'(dbus.det_valid), 0);

        // full FIFO with simultaneous push and pop
        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b1, 11'(100 + i), 16'h0300, 1'b0);
        step(1'b1, 1'b1, 11'd116, 16'h0300, 1'b1);
        chk("pp_ovf", 32'(overflow), 0);
        chk("pp_head", 32'(dbus.det_sw_id), 101);
        for (int i = 0; i < 16; i++) begin
            chk("pp_drain", 32'(dbus.det_sw_id), 32'(101 + i));
            idle(1'b1);
        end
        chk("pp_empty", 32'(dbus.det_valid), 0);
        close(1'b1);
        chk("pp_fcnt", 32'(frame_cnt), 17);

        // full frame, detection on the closing window
        for (int w = 0; w < SW_N; w++) begin
            p = (w == 5) || (w == 500) || (w == SW_N - 1);
            step(1'b1, p, 11'(w), p ? 16'h4000 : 16'h0050, 1'b1);
        end
        chk("frm_done", 32'(frame_done), 1);
        chk("frm_cnt", 32'(frame_cnt), 3);
        idle(1'b1);
        chk("frm_pulse", 32'(frame_done), 0);

        // LED hold of two frames
        hold_fr = 4'd2;
        step(1'b1, 1'b1, 11'd7, 16'h4000, 1'b1);
        close(1'b1);
        chk("led_on", 32'(led), 1);
        close(1'b1);
        chk("led_hold", 32'(led), 1);
        close(1'b1);
        chk("led_off", 32'(led), 0);

        // asynchronous reset with queued entries and led lit
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 11'(200 + i), 16'h4000, 1'b0);
        close(1'b0);
        chk("pre_rst_led", 32'(led), 1);
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_valid", 32'(dbus.det_valid), 0);
        chk("arst_led", 32'(led), 0);
        chk("arst_fcnt", 32'(frame_cnt), 0);
        check_all();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b1, 11'd2047, 16'h7FFF, 1'b0);
        step(1'b1, 1'b1, 11'(SW_N), 16'h7FFF, 1'b0);
        chk("oor_valid", 32'(dbus.det_valid), 0);
        chk("oor_done", 32'(frame_done), 0);
        chk("oor_led", 32'(led), 0);
        chk("oor_fcnt", 32'(frame_cnt), 0);

        // counter saturation
        thr      = 16'h8000;
        thr_load = 1'b1;
        idle(1'b1);
        thr_load = 1'b0;
        for (int i = 0; i < 300; i++)
            step(1'b1, 1'b1, 11'(i), 16'h0000, 1'b1);
        close(1'b1);
        chk("sat_cnt", 32'(frame_cnt), 255);

        // randomized traffic at varying consumer rates
        for (int ph = 0; ph < 8; ph++) begin
            rdy_pct = (ph % 4) * 30;
            for (int c = 0; c < 500; c++) begin
                r = $urandom_range(99);
                if (r < 6) rid = LAST;
                else if (r < 12) rid = 11'($urandom_range(2047, SW_N));
                else rid = 11'($urandom_range(SW_N - 2));
                thr      = 16'($urandom);
                thr_load = ($urandom_range(49) == 0);
                hold_fr  = 4'($urandom_range(3));
                step($urandom_range(99) < 80, 1'($urandom_range(1)),
                     rid, 16'($urandom),
                     $urandom_range(99) < rdy_pct);
            end
        end
        thr_load = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
